// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, and a
// byte register with one-cycle data_ready / frame_error strobes.
module uart_receiver #(
    parameter int SIGNAL_DURATION = 433
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       data_ready,
    output logic       frame_error,
    output logic       busy
);

    localparam int HALF  = SIGNAL_DURATION / 2;
    localparam int CNT_W = $clog2(SIGNAL_DURATION + 1);
    localparam logic [CNT_W-1:0] BIT_LIMIT  = CNT_W'(SIGNAL_DURATION);
    localparam logic [CNT_W-1:0] HALF_LIMIT = CNT_W'(HALF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_rx_meta;
    logic               r_rx_s;
    logic [CNT_W-1:0]   r_timer;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_rx_data;
    logic               r_data_ready;
    logic               r_frame_error;

    logic               w_timer_clr;
    logic               w_timer_run;
    logic               w_shift_en;
    logic               w_idx_clr;
    logic               w_frame_good;
    logic               w_frame_bad;

    // Both flops come out of reset high so an idle line is never seen as a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking so each flop captures the previous value, forming a real two-stage chain.
            r_rx_meta <= RxD;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latch).
        w_next_state = r_state;
        w_timer_clr  = 1'b0;
        w_shift_en   = 1'b0;
        w_idx_clr    = 1'b0;
        w_frame_good = 1'b0;
        w_frame_bad  = 1'b0;
        w_timer_run  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_next_state = S_START;
                    w_timer_clr  = 1'b1;
                end
            end
            S_START: begin
                w_timer_run = 1'b1;
                if (r_timer == HALF_LIMIT) begin
                    w_timer_clr = 1'b1;
                    if (r_rx_s) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_DATA;
                        w_idx_clr    = 1'b1;
                    end
                end
            end
            S_DATA: begin
                w_timer_run = 1'b1;
                if (r_timer == BIT_LIMIT) begin
                    w_timer_clr = 1'b1;
                    w_shift_en  = 1'b1;
                    if (r_idx == 3'd7) begin
                        w_next_state = S_STOP;
                    end
                end
            end
            S_STOP: begin
                w_timer_run = 1'b1;
                if (r_timer == BIT_LIMIT) begin
                    w_timer_clr = 1'b1;
                    if (r_rx_s) begin
                        w_frame_good = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_frame_bad  = 1'b1;
                        w_next_state = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (r_rx_s) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Timer only runs while measuring an interval; it is held at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (w_timer_clr || !w_timer_run) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            if (w_idx_clr) begin
                r_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_shift[r_idx] <= r_rx_s;
                r_idx          <= r_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data     <= 8'h00;
            r_data_ready  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_data_ready  <= w_frame_good;
            r_frame_error <= w_frame_bad;
            if (w_frame_good) begin
                r_rx_data <= r_shift;
            end
        end
    end

    assign RxD_data    = r_rx_data;
    assign data_ready  = r_data_ready;
    assign frame_error = r_frame_error;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a short-bit instance for frame/glitch/error/reset
// cases and a full-rate instance for mid-bit timing of one frame.
module tb_uart_receiver;

    localparam int SD_A  = 3;
    localparam int SD_B  = 433;
    localparam int BIT_A = SD_A + 1;
    localparam int BIT_B = SD_B + 1;

    logic       clk;
    logic       rst_n;
    logic       rx_a;
    logic       rx_b;
    logic [7:0] data_a;
    logic       ready_a;
    logic       ferr_a;
    logic       busy_a;
    logic [7:0] data_b;
    logic       ready_b;
    logic       ferr_b;
    logic       busy_b;

    int         n_total;
    int         n_bad;
    int         ferr_cnt_a;
    int         ferr_cnt_b;
    int         overlap_cnt;
    int         long_pulse_cnt;
    int         cyc;
    int         ready_cyc_b;
    logic       prev_ready_a;
    logic       prev_ferr_a;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    uart_receiver #(.SIGNAL_DURATION(SD_A)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RxD         (rx_a),
        .RxD_data    (data_a),
        .data_ready  (ready_a),
        .frame_error (ferr_a),
        .busy        (busy_a)
    );

    uart_receiver #(.SIGNAL_DURATION(SD_B)) dut_long (
        .clk         (clk),
        .rst_n       (rst_n),
        .RxD         (rx_b),
        .RxD_data    (data_b),
        .data_ready  (ready_b),
        .frame_error (ferr_b),
        .busy        (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (ready_a) q_a.push_back(data_a);
        if (ferr_a) ferr_cnt_a++;
        if (ready_a && ferr_a) overlap_cnt++;
        if ((ready_a && prev_ready_a) || (ferr_a && prev_ferr_a)) long_pulse_cnt++;
        prev_ready_a = ready_a;
        prev_ferr_a  = ferr_a;
        if (ready_b) begin
            q_b.push_back(data_b);
            ready_cyc_b = cyc;
        end
        if (ferr_b) ferr_cnt_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] q_at(input int i);
        return (i < q_a.size()) ? q_a[i] : 8'hxx;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input logic v, input bit line_b);
        if (line_b) rx_b = v;
        else        rx_a = v;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int n, input bit line_b);
        set_rx(1'b0, line_b);
        wait_clks(n);
        for (int i = 0; i < 8; i++) begin
            set_rx(b[i], line_b);
            wait_clks(n);
        end
        set_rx(stop_v, line_b);
        wait_clks(n);
    endtask

    initial begin
        int busy_hi;
        int c0;
        n_total        = 0;
        n_bad          = 0;
        ferr_cnt_a     = 0;
        ferr_cnt_b     = 0;
        overlap_cnt    = 0;
        long_pulse_cnt = 0;
        cyc            = 0;
        ready_cyc_b    = 0;
        prev_ready_a   = 1'b0;
        prev_ferr_a    = 1'b0;
        rx_a           = 1'b1;
        rx_b           = 1'b1;
        rst_n          = 1'b0;

        wait_clks(3);
        check("reset_data",  {24'h0, data_a}, 32'h00);
        check("reset_ready", {31'h0, ready_a}, 32'h0);
        check("reset_ferr",  {31'h0, ferr_a}, 32'h0);
        check("reset_busy",  {31'h0, busy_a}, 32'h0);
        check("reset_busy_long", {31'h0, busy_b}, 32'h0);
        rst_n = 1'b1;
        wait_clks(4);

        // Two separated frames.
        send_frame(8'h5D, 1'b1, BIT_A, 1'b0);
        wait_clks(6);
        send_frame(8'h65, 1'b1, BIT_A, 1'b0);
        wait_clks(8);
        check("t1_count", q_a.size(), 32'd2);
        check("t1_byte0", {24'h0, q_at(0)}, 32'h5D);
        check("t1_byte1", {24'h0, q_at(1)}, 32'h65);
        check("t1_held",  {24'h0, data_a}, 32'h65);
        check("t1_ferr",  ferr_cnt_a, 32'd0);
        q_a.delete();

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b1, BIT_A, 1'b0);
        send_frame(8'hFF, 1'b1, BIT_A, 1'b0);
        send_frame(8'hA5, 1'b1, BIT_A, 1'b0);
        wait_clks(8);
        check("t2_count", q_a.size(), 32'd3);
        check("t2_byte0", {24'h0, q_at(0)}, 32'h00);
        check("t2_byte1", {24'h0, q_at(1)}, 32'hFF);
        check("t2_byte2", {24'h0, q_at(2)}, 32'hA5);
        q_a.delete();

        // One-clock glitch: start detected, rejected at the half-bit check.
        rx_a = 1'b0;
        wait_clks(1);
        rx_a = 1'b1;
        busy_hi = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy_a) busy_hi++;
        end
        @(posedge clk);
        #1;
        check("t3_busy_cycles", busy_hi, 32'd2);
        check("t3_busy_low",  {31'h0, busy_a}, 32'h0);
        check("t3_no_ready",  q_a.size(), 32'd0);

        // Stop bit low, line held low, then released.
        send_frame(8'h3C, 1'b0, BIT_A, 1'b0);
        wait_clks(40);
        check("t4_busy_held", {31'h0, busy_a}, 32'h1);
        check("t4_ferr_cnt",  ferr_cnt_a, 32'd1);
        check("t4_data_kept", {24'h0, data_a}, 32'hA5);
        check("t4_no_ready",  q_a.size(), 32'd0);
        rx_a = 1'b1;
        wait_clks(5);
        check("t4_busy_free", {31'h0, busy_a}, 32'h0);
        send_frame(8'h3C, 1'b1, BIT_A, 1'b0);
        wait_clks(8);
        check("t4_recover_cnt",  q_a.size(), 32'd1);
        check("t4_recover_byte", {24'h0, q_at(0)}, 32'h3C);
        check("t4_ferr_final",   ferr_cnt_a, 32'd1);
        q_a.delete();

        // Reset asserted during D4 of 8'hC3.
        rx_a = 1'b0;
        wait_clks(BIT_A);
        for (int i = 0; i < 4; i++) begin
            rx_a = (8'hC3 >> i) & 8'h01;
            wait_clks(BIT_A);
        end
        rx_a = 1'b0;
        wait_clks(2);
        rst_n = 1'b0;
        rx_a  = 1'b1;
        #2;
        check("t5_rst_data",  {24'h0, data_a}, 32'h00);
        check("t5_rst_ready", {31'h0, ready_a}, 32'h0);
        check("t5_rst_busy",  {31'h0, busy_a}, 32'h0);
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(3);
        send_frame(8'h81, 1'b1, BIT_A, 1'b0);
        wait_clks(8);
        check("t5_count", q_a.size(), 32'd1);
        check("t5_byte",  {24'h0, q_at(0)}, 32'h81);

        // Full-rate frame: stop mid-point at 9*434+217, plus 3 clocks latency.
        c0 = cyc;
        send_frame(8'h55, 1'b1, BIT_B, 1'b1);
        wait_clks(20);
        check("t6_count",   q_b.size(), 32'd1);
        check("t6_byte",    {24'h0, data_b}, 32'h55);
        check("t6_latency", ready_cyc_b - c0, 32'd4126);
        check("t6_ferr",    ferr_cnt_b, 32'd0);

        check("overlap_pulses", overlap_cnt, 32'd0);
        check("long_pulses",    long_pulse_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
